// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality checks for the parametrised FIFO.
package fifo_pkg;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// DEPTH x DATA_WIDTH dual-port RAM: synchronous write, registered read with
// write-through when the same address is written and read on one edge.
module sync_fifo_param_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-through lets a word written into an empty FWFT FIFO appear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with fill count, almost-full/empty flags,
// overflow/underflow pulses and optional first-word-fall-through read mode.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4,
  parameter int FWFT          = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     winc,
  output logic                     wfull,
  output logic                     wafull,
  output logic                     wovf,
  input  logic                     rinc,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rempty,
  output logic                     raempty,
  output logic                     rudf,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("sync_fifo_param: almost-full/almost-empty threshold out of range");
  end

  logic [PW-1:0] wptr, rptr, rptr_nx;
  logic [CW-1:0] cnt_nx;
  logic          wr_ok, rd_ok;
  logic          mem_re;
  logic [PW-1:0] mem_raddr;

  assign wr_ok = winc && !wfull;
  assign rd_ok = rinc && !rempty;

  always_comb begin
    cnt_nx  = count;
    rptr_nx = rptr;
    if (wr_ok && !rd_ok) cnt_nx = count + CW'(1);
    else if (rd_ok && !wr_ok) cnt_nx = count - CW'(1);
    if (rd_ok) rptr_nx = rptr + PW'(1);
  end

  // Standard mode loads rdata only on a pop; FWFT keeps the head word preloaded.
  assign mem_re    = (FWFT != 0) ? (cnt_nx != '0) : rd_ok;
  assign mem_raddr = (FWFT != 0) ? rptr_nx : rptr;

  sync_fifo_param_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wptr),
    .wdata (wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      wfull   <= 1'b0;
      wafull  <= (AFULL_THRESH == 0);
      wovf    <= 1'b0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
      rudf    <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      rptr    <= rptr_nx;
      count   <= cnt_nx;
      wfull   <= (cnt_nx == CW'(DEPTH));
      wafull  <= (cnt_nx >= CW'(AFULL_THRESH));
      wovf    <= winc && wfull;
      rempty  <= (cnt_nx == '0);
      raempty <= (cnt_nx <= CW'(AEMPTY_THRESH));
      rudf    <= rinc && rempty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench driving a standard-read and an FWFT instance with identical stimulus,
// checked against a queue-based occupancy/data model.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;

  logic          wfull_0, wafull_0, wovf_0, rempty_0, raempty_0, rudf_0;
  logic          wfull_1, wafull_1, wovf_1, rempty_1, raempty_1, rudf_1;
  logic [DW-1:0] rdata_0, rdata_1;
  logic [4:0]    count_0, count_1;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull_0),
    .wafull(wafull_0), .wovf(wovf_0), .rinc(rinc), .rdata(rdata_0),
    .rempty(rempty_0), .raempty(raempty_0), .rudf(rudf_0), .count(count_0));

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF),
                    .AEMPTY_THRESH(AE), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .wfull(wfull_1),
    .wafull(wafull_1), .wovf(wovf_1), .rinc(rinc), .rdata(rdata_1),
    .rempty(rempty_1), .raempty(raempty_1), .rudf(rudf_1), .count(count_1));

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: FIFO contents as a queue
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_0 = '0;
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;
  logic          pop_0 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      last_0  = '0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
      pop_0   = 1'b0;
    end else begin
      int sz;
      sz      = m_q.size();
      exp_ovf = winc && (sz == DEPTH);
      exp_udf = rinc && (sz == 0);
      pop_0   = rinc && (sz > 0);
      if (pop_0) exp_q.push_back(m_q.pop_front());
      if (winc && (sz < DEPTH)) m_q.push_back(wdata);
    end
  end

  // monitor: compares status every cycle, pops the scoreboard when a read completes
  always @(negedge clk) begin
    int sz;
    sz = m_q.size();
    chk("count_std", 32'(count_0), 32'(sz));
    chk("count_fwft", 32'(count_1), 32'(sz));
    chk("wfull", 32'({wfull_1, wfull_0}), sz == DEPTH ? 32'h3 : 32'h0);
    chk("wafull", 32'({wafull_1, wafull_0}), sz >= AF ? 32'h3 : 32'h0);
    chk("rempty", 32'({rempty_1, rempty_0}), sz == 0 ? 32'h3 : 32'h0);
    chk("raempty", 32'({raempty_1, raempty_0}), sz <= AE ? 32'h3 : 32'h0);
    chk("wovf", 32'({wovf_1, wovf_0}), exp_ovf ? 32'h3 : 32'h0);
    chk("rudf", 32'({rudf_1, rudf_0}), exp_udf ? 32'h3 : 32'h0);
    if (pop_0) begin
      if (exp_q.size() == 0) chk("rdata_std_queue", 32'(exp_q.size()), 32'd1);
      else begin
        last_0 = exp_q.pop_front();
        chk("rdata_std", 32'(rdata_0), 32'(last_0));
      end
    end else begin
      chk("rdata_std_hold", 32'(rdata_0), 32'(last_0));
    end
    if (!rempty_1 && sz > 0) chk("rdata_fwft_head", 32'(rdata_1), 32'(m_q[0]));
  end

  // driver tasks
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_to(input int n);
    while (m_q.size() < n) cycle(1'b1, 1'b0, DW'($urandom_range(0, 255)));
  endtask

  task automatic drain();
    while (m_q.size() > 0) cycle(1'b0, 1'b1, '0);
  endtask

  int pw_tab[6] = '{90, 20, 50, 70, 30, 100};
  int pr_tab[6] = '{20, 90, 50, 70, 30, 100};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", 32'(count_0), 32'd0);
    chk("reset_rempty", 32'({rempty_1, rempty_0, raempty_0}), 32'h7);
    chk("reset_rdata", 32'({rdata_1, rdata_0}), 32'h0);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0);

    // fill with 0x00..0x0F, then one overflowing write
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i));
    chk("fill_count", 32'(count_0), 32'd16);
    chk("fill_wfull", 32'(wfull_0), 32'd1);
    cycle(1'b1, 1'b0, 8'hEE);
    chk("ovf_pulse", 32'(wovf_0), 32'd1);
    chk("ovf_count", 32'(count_0), 32'd16);

    // drain all, then one underflowing read
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, '0);
    chk("drain_last", 32'(rdata_0), 32'h0F);
    cycle(1'b0, 1'b1, '0);
    chk("udf_pulse", 32'(rudf_0), 32'd1);
    chk("udf_hold", 32'(rdata_0), 32'h0F);

    // steady state at 8 across pointer wrap
    fill_to(8);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, DW'($urandom_range(0, 255)));
    chk("steady_count", 32'(count_0), 32'd8);
    drain();
    cycle(1'b0, 1'b0, '0);

    // FWFT: word appears without a read request
    cycle(1'b1, 1'b0, 8'hA5);
    chk("fwft_rempty", 32'(rempty_1), 32'd0);
    chk("fwft_rdata", 32'(rdata_1), 32'hA5);
    cycle(1'b0, 1'b1, '0);
    chk("fwft_pop_empty", 32'(rempty_1), 32'd1);

    // full with simultaneous read+write, then empty with simultaneous read+write
    fill_to(DEPTH);
    cycle(1'b1, 1'b1, 8'h77);
    chk("full_rw_ovf", 32'(wovf_0), 32'd1);
    chk("full_rw_count", 32'(count_0), 32'd15);
    drain();
    cycle(1'b1, 1'b1, 8'h5A);
    chk("empty_rw_udf", 32'(rudf_0), 32'd1);
    chk("empty_rw_count", 32'(count_1), 32'd1);
    drain();

    // asynchronous reset mid-burst
    fill_to(9);
    winc = 1'b1;
    wdata = 8'h99;
    rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'({count_1, count_0}), 32'h0);
    chk("midrst_flags", 32'({rempty_0, raempty_0, wfull_0, wafull_0, wovf_0, rudf_0}), 32'h30);
    chk("midrst_rdata", 32'({rdata_1, rdata_0}), 32'h0);
    winc = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h3C);
    chk("postrst_fwft", 32'(rdata_1), 32'h3C);
    cycle(1'b1, 1'b1, 8'h4D);
    chk("postrst_std", 32'(rdata_0), 32'h3C);
    drain();

    // randomized traffic in phases of differing write/read pressure
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 200; i++) begin
        cycle($urandom_range(0, 99) < pw_tab[p % 6], $urandom_range(0, 99) < pr_tab[p % 6],
              DW'($urandom_range(0, 255)));
      end
    end
    cycle(1'b0, 1'b0, '0);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
